// File: rtl/aesl_deadlock_pkg.sv
// Shared types and helpers for the kernel deadlock channel monitor.
package aesl_deadlock_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WATCH    = 2'd1,
    DEADLOCK = 2'd2
  } monitor_state_t;

  // Deadlock-entry counter width and its saturation value.
  localparam int                  DCOUNT_W   = 8;
  localparam logic [DCOUNT_W-1:0] DCOUNT_MAX = 8'hFF;

  // Channel index width; a single channel still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/aesl_deadlock_prio_enc.sv
// Lowest-set-bit priority encoder over the channel block flags.
module aesl_deadlock_prio_enc #(
  parameter int NUM_AXIS = 4,
  parameter int IDX_W    = 2
) (
  input  logic [NUM_AXIS-1:0] sigs,
  output logic [IDX_W-1:0]    idx,
  output logic                valid
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = NUM_AXIS - 1; i >= 0; i--) begin
      if (sigs[i]) idx = IDX_W'(i);
    end
  end

  assign valid = |sigs;

endmodule

// File: rtl/aesl_deadlock_channel_monitor.sv
// Kernel deadlock monitor: a stall must persist THRESHOLD cycles before a
// sticky deadlock is reported; the first blocked channel is latched on entry.
// The FSM state is kept in the signal `state` for checkers to bind to.
module aesl_deadlock_channel_monitor
  import aesl_deadlock_pkg::*;
#(
  parameter int NUM_AXIS  = 4,
  parameter int NUM_INST  = 2,
  parameter int CNT_W     = 16,
  parameter int THRESHOLD = 64,
  parameter int IDX_W     = idx_width(NUM_AXIS)
) (
  input  logic                kernel_monitor_clock,
  input  logic                kernel_monitor_reset,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [NUM_INST-1:0] inst_idle_sigs,
  input  logic [NUM_INST-1:0] inst_block_sigs,
  input  logic                clear,
  output logic                kernel_block,
  output logic [IDX_W-1:0]    blocked_chan_idx,
  output logic [CNT_W-1:0]    stall_cycles,
  output logic [DCOUNT_W-1:0] deadlock_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W:0]   THRESH  = (CNT_W + 1)'(THRESHOLD);

  monitor_state_t   state;
  monitor_state_t   state_next;
  logic             stall;
  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W-1:0] cnt_next;
  logic             kb_next;
  logic             enter_dl;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_valid;

  // A channel is blocked and every instance is either idle or blocked.
  assign stall   = (|axis_block_sigs) & (&(inst_idle_sigs | inst_block_sigs));
  assign cnt_inc = {1'b0, stall_cycles} + 1'b1;

  aesl_deadlock_prio_enc #(
    .NUM_AXIS (NUM_AXIS),
    .IDX_W    (IDX_W)
  ) u_prio_enc (
    .sigs  (axis_block_sigs),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  // State register.
  always_ff @(posedge kernel_monitor_clock or negedge kernel_monitor_reset) begin
    if (!kernel_monitor_reset) state <= IDLE;
    else                       state <= state_next;
  end

  // Next-state logic; clear wins over every transition, including entry.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:     if (stall) state_next = (THRESHOLD == 1) ? DEADLOCK : WATCH;
        WATCH: begin
          if (!stall)                 state_next = IDLE;
          else if (cnt_inc == THRESH) state_next = DEADLOCK;
        end
        DEADLOCK: state_next = DEADLOCK;
        default:  state_next = IDLE;
      endcase
    end
  end

  // Output decode: next values for the registered outputs.
  always_comb begin
    cnt_next = stall_cycles;
    kb_next  = (state_next == DEADLOCK);
    enter_dl = (state != DEADLOCK) && (state_next == DEADLOCK);
    if (clear) begin
      cnt_next = '0;
    end else begin
      case (state)
        IDLE:     cnt_next = stall ? CNT_W'(1) : '0;
        WATCH:    cnt_next = stall ? cnt_inc[CNT_W-1:0] : '0;
        DEADLOCK: if (stall && (stall_cycles != CNT_MAX)) cnt_next = cnt_inc[CNT_W-1:0];
        default:  cnt_next = '0;
      endcase
    end
  end

  // Registered outputs; index and entry count only move on deadlock entry.
  always_ff @(posedge kernel_monitor_clock or negedge kernel_monitor_reset) begin
    if (!kernel_monitor_reset) begin
      kernel_block     <= 1'b0;
      stall_cycles     <= '0;
      blocked_chan_idx <= '0;
      deadlock_count   <= '0;
    end else begin
      kernel_block <= kb_next;
      stall_cycles <= cnt_next;
      if (enter_dl && enc_valid) begin
        blocked_chan_idx <= enc_idx;
        if (deadlock_count != DCOUNT_MAX) deadlock_count <= deadlock_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aesl_deadlock_channel_monitor.sv
// Bench for the deadlock monitor: three instances (threshold 8, a 4-bit
// counter with threshold 15, and threshold 1) against a rule-level model.
module tb_aesl_deadlock_channel_monitor;

  logic clk;
  logic rst_n;

  // Instance A: NUM_AXIS=4, NUM_INST=2, CNT_W=16, THRESHOLD=8
  logic [3:0]  a_axis;
  logic [1:0]  a_idle, a_blk;
  logic        a_clr, a_kb;
  logic [1:0]  a_idx;
  logic [15:0] a_cnt;
  logic [7:0]  a_dc;

  // Instance B: NUM_AXIS=4, NUM_INST=2, CNT_W=4, THRESHOLD=15
  logic [3:0]  b_axis;
  logic [1:0]  b_idle, b_blk;
  logic        b_clr, b_kb;
  logic [1:0]  b_idx;
  logic [3:0]  b_cnt;
  logic [7:0]  b_dc;

  // Instance C: NUM_AXIS=1, NUM_INST=1, CNT_W=16, THRESHOLD=1
  logic [0:0]  c_axis, c_idle, c_blk;
  logic        c_clr, c_kb;
  logic [0:0]  c_idx;
  logic [15:0] c_cnt;
  logic [7:0]  c_dc;

  int checks = 0;
  int errors = 0;

  // Reference model state, one slot per instance.
  bit m_dl  [3];
  int m_cnt [3];
  int m_idx [3];
  int m_dc  [3];
  int m_th  [3] = '{8, 15, 1};
  int m_cmax[3] = '{65535, 15, 65535};
  logic [1:0] exp_q[$];

  aesl_deadlock_channel_monitor #(.NUM_AXIS(4), .NUM_INST(2), .CNT_W(16), .THRESHOLD(8)) dut_a (
    .kernel_monitor_clock(clk), .kernel_monitor_reset(rst_n),
    .axis_block_sigs(a_axis), .inst_idle_sigs(a_idle), .inst_block_sigs(a_blk),
    .clear(a_clr), .kernel_block(a_kb), .blocked_chan_idx(a_idx),
    .stall_cycles(a_cnt), .deadlock_count(a_dc));

  aesl_deadlock_channel_monitor #(.NUM_AXIS(4), .NUM_INST(2), .CNT_W(4), .THRESHOLD(15)) dut_b (
    .kernel_monitor_clock(clk), .kernel_monitor_reset(rst_n),
    .axis_block_sigs(b_axis), .inst_idle_sigs(b_idle), .inst_block_sigs(b_blk),
    .clear(b_clr), .kernel_block(b_kb), .blocked_chan_idx(b_idx),
    .stall_cycles(b_cnt), .deadlock_count(b_dc));

  aesl_deadlock_channel_monitor #(.NUM_AXIS(1), .NUM_INST(1), .CNT_W(16), .THRESHOLD(1)) dut_c (
    .kernel_monitor_clock(clk), .kernel_monitor_reset(rst_n),
    .axis_block_sigs(c_axis), .inst_idle_sigs(c_idle), .inst_block_sigs(c_blk),
    .clear(c_clr), .kernel_block(c_kb), .blocked_chan_idx(c_idx),
    .stall_cycles(c_cnt), .deadlock_count(c_dc));

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // A kernel is stalled when some channel is blocked and no instance progresses.
  function automatic bit stall_of(input logic [3:0] axis, input logic [1:0] idle,
                                  input logic [1:0] blk);
    int progressing = 0;
    for (int i = 0; i < 2; i++) if (!idle[i] && !blk[i]) progressing++;
    return (axis != 4'd0) && (progressing == 0);
  endfunction

  function automatic int lowest4(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_dl[k] = 0; m_cnt[k] = 0; m_idx[k] = 0; m_dc[k] = 0;
    end
  endtask

  // One clock edge of the monitoring rules for instance k.
  task automatic model_edge(input int k, input bit stall, input int low, input bit clr);
    if (clr) begin
      m_dl[k] = 0;
      m_cnt[k] = 0;
    end else if (m_dl[k]) begin
      if (stall && m_cnt[k] < m_cmax[k]) m_cnt[k]++;
    end else if (stall) begin
      m_cnt[k]++;
      if (m_cnt[k] == m_th[k]) begin
        m_dl[k] = 1;
        m_idx[k] = low;
        if (m_dc[k] < 255) m_dc[k]++;
        if (k == 0) exp_q.push_back(2'(low));
      end
    end else begin
      m_cnt[k] = 0;
    end
  endtask

  // Driver: inputs are already set; advance one edge and settle.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      model_edge(0, stall_of(a_axis, a_idle, a_blk), lowest4(a_axis), a_clr);
      model_edge(1, stall_of(b_axis, b_idle, b_blk), lowest4(b_axis), b_clr);
      model_edge(2, c_axis[0] && (c_idle[0] || c_blk[0]), 0, c_clr);
    end
    #1;
  endtask

  task automatic set_a(input logic [3:0] axis, input logic [1:0] idle,
                       input logic [1:0] blk, input logic clr);
    a_axis = axis; a_idle = idle; a_blk = blk; a_clr = clr;
  endtask

  task automatic test_reset();
    checks++; if (a_kb !== 1'b0)   begin errors++; $display("FAIL reset_a_kb got %0d exp 0", a_kb); end
    checks++; if (a_idx !== 2'd0)  begin errors++; $display("FAIL reset_a_idx got %0d exp 0", a_idx); end
    checks++; if (a_cnt !== 16'd0) begin errors++; $display("FAIL reset_a_cnt got %0d exp 0", a_cnt); end
    checks++; if (a_dc !== 8'd0)   begin errors++; $display("FAIL reset_a_dc got %0d exp 0", a_dc); end
    checks++; if (b_kb !== 1'b0 || b_cnt !== 4'd0 || b_dc !== 8'd0 || b_idx !== 2'd0)
      begin errors++; $display("FAIL reset_b got kb=%0d cnt=%0d dc=%0d idx=%0d exp 0", b_kb, b_cnt, b_dc, b_idx); end
    checks++; if (c_kb !== 1'b0 || c_cnt !== 16'd0 || c_dc !== 8'd0 || c_idx !== 1'b0)
      begin errors++; $display("FAIL reset_c got kb=%0d cnt=%0d dc=%0d idx=%0d exp 0", c_kb, c_cnt, c_dc, c_idx); end
  endtask

  task automatic test_persistence();
    set_a(4'b0100, 2'b11, 2'b00, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++; if (a_cnt !== 16'(i)) begin errors++; $display("FAIL persist_cnt got %0d exp %0d", a_cnt, i); end
      checks++; if (a_kb !== (i == 8)) begin errors++; $display("FAIL persist_kb cycle %0d got %0d exp %0d", i, a_kb, i == 8); end
    end
    checks++; if (a_idx !== 2'd2) begin errors++; $display("FAIL persist_idx got %0d exp 2", a_idx); end
    checks++; if (a_dc !== 8'd1)  begin errors++; $display("FAIL persist_dc got %0d exp 1", a_dc); end
    set_a(4'b0000, 2'b11, 2'b00, 1'b1);
    tick();
    a_clr = 1'b0;
    checks++; if (a_kb !== 1'b0 || a_cnt !== 16'd0) begin errors++; $display("FAIL persist_clear got kb=%0d cnt=%0d exp 0", a_kb, a_cnt); end
  endtask

  task automatic test_glitch_filter();
    set_a(4'b0011, 2'b01, 2'b10, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    checks++; if (a_cnt !== 16'd7 || a_kb !== 1'b0) begin errors++; $display("FAIL glitch_pre got cnt=%0d kb=%0d exp 7 0", a_cnt, a_kb); end
    a_idle = 2'b00; a_blk = 2'b01;
    tick();
    checks++; if (a_cnt !== 16'd0) begin errors++; $display("FAIL glitch_gap got cnt=%0d exp 0", a_cnt); end
    a_idle = 2'b01; a_blk = 2'b10;
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++; if (a_kb !== (i == 8)) begin errors++; $display("FAIL glitch_kb cycle %0d got %0d exp %0d", i, a_kb, i == 8); end
    end
    checks++; if (a_idx !== 2'd0 || a_dc !== m_dc[0][7:0]) begin errors++; $display("FAIL glitch_entry got idx=%0d dc=%0d exp 0 %0d", a_idx, a_dc, m_dc[0]); end
    set_a(4'b0000, 2'b00, 2'b00, 1'b1);
    tick();
    a_clr = 1'b0;
  endtask

  task automatic test_progress_masks();
    set_a(4'b0001, 2'b00, 2'b00, 1'b0);
    for (int i = 0; i < 100; i++) begin
      a_idle = 2'($urandom_range(0, 2)) & 2'b01;
      tick();
      checks++; if (a_kb !== 1'b0 || a_cnt !== 16'd0) begin errors++; $display("FAIL progress got kb=%0d cnt=%0d exp 0 0", a_kb, a_cnt); end
    end
  endtask

  task automatic test_priority_clear();
    int dc0;
    dc0 = m_dc[0];
    set_a(4'b1010, 2'b11, 2'b00, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    checks++; if (a_kb !== 1'b1 || a_idx !== 2'd1) begin errors++; $display("FAIL prio_first got kb=%0d idx=%0d exp 1 1", a_kb, a_idx); end
    set_a(4'b0000, 2'b11, 2'b00, 1'b1);
    tick();
    a_clr = 1'b0;
    checks++; if (a_kb !== 1'b0 || a_idx !== 2'd1) begin errors++; $display("FAIL prio_clear got kb=%0d idx=%0d exp 0 1", a_kb, a_idx); end
    a_axis = 4'b1000;
    for (int i = 0; i < 8; i++) tick();
    checks++; if (a_kb !== 1'b1 || a_idx !== 2'd3) begin errors++; $display("FAIL prio_second got kb=%0d idx=%0d exp 1 3", a_kb, a_idx); end
    checks++; if (a_dc !== 8'(dc0 + 2)) begin errors++; $display("FAIL prio_dc got %0d exp %0d", a_dc, dc0 + 2); end
    set_a(4'b0000, 2'b00, 2'b00, 1'b1);
    tick();
    a_clr = 1'b0;
  endtask

  task automatic test_clear_collision();
    logic [7:0] dc_before;
    dc_before = a_dc;
    set_a(4'b0110, 2'b10, 2'b01, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    a_clr = 1'b1;
    tick();
    checks++; if (a_kb !== 1'b0)  begin errors++; $display("FAIL collide_kb got %0d exp 0", a_kb); end
    checks++; if (a_cnt !== 16'd0) begin errors++; $display("FAIL collide_cnt got %0d exp 0", a_cnt); end
    checks++; if (a_dc !== dc_before) begin errors++; $display("FAIL collide_dc got %0d exp %0d", a_dc, dc_before); end
    a_clr = 1'b0;
    tick();
    checks++; if (a_cnt !== 16'd1) begin errors++; $display("FAIL collide_restart got %0d exp 1", a_cnt); end
    a_axis = 4'b0000;
    tick();
  endtask

  task automatic test_random();
    logic prev_kb;
    logic [1:0] exp_idx;
    exp_q.delete();
    for (int i = 0; i < 1500; i++) begin
      a_axis = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(1, 15)) : 4'd0;
      a_idle = 2'($urandom_range(0, 3));
      a_blk  = ($urandom_range(0, 19) < 19) ? ~a_idle : 2'($urandom_range(0, 3));
      a_clr  = ($urandom_range(0, 59) == 0);
      prev_kb = a_kb;
      tick();
      checks++; if (a_kb !== m_dl[0])        begin errors++; $display("FAIL rand_kb cyc %0d got %0d exp %0d", i, a_kb, m_dl[0]); end
      checks++; if (a_cnt !== m_cnt[0][15:0]) begin errors++; $display("FAIL rand_cnt cyc %0d got %0d exp %0d", i, a_cnt, m_cnt[0]); end
      checks++; if (a_dc !== m_dc[0][7:0])    begin errors++; $display("FAIL rand_dc cyc %0d got %0d exp %0d", i, a_dc, m_dc[0]); end
      checks++; if (a_idx !== m_idx[0][1:0])  begin errors++; $display("FAIL rand_idx cyc %0d got %0d exp %0d", i, a_idx, m_idx[0]); end
      if (!prev_kb && a_kb === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_entry cyc %0d got unexpected entry exp none", i);
        end else begin
          exp_idx = exp_q.pop_front();
          if (a_idx !== exp_idx) begin errors++; $display("FAIL rand_entry_idx cyc %0d got %0d exp %0d", i, a_idx, exp_idx); end
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_pending got %0d exp 0", exp_q.size()); end
    set_a(4'b0000, 2'b00, 2'b00, 1'b1);
    tick();
    a_clr = 1'b0;
  endtask

  task automatic test_saturation();
    b_axis = 4'b0110; b_idle = 2'b01; b_blk = 2'b10;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++; if (b_cnt !== m_cnt[1][3:0]) begin errors++; $display("FAIL sat_cnt cycle %0d got %0d exp %0d", i, b_cnt, m_cnt[1]); end
      checks++; if (b_kb !== (i >= 15)) begin errors++; $display("FAIL sat_kb cycle %0d got %0d exp %0d", i, b_kb, i >= 15); end
    end
    checks++; if (b_cnt !== 4'd15 || b_idx !== 2'd1 || b_dc !== 8'd1)
      begin errors++; $display("FAIL sat_final got cnt=%0d idx=%0d dc=%0d exp 15 1 1", b_cnt, b_idx, b_dc); end
  endtask

  task automatic test_threshold_one();
    for (int i = 1; i <= 300; i++) begin
      c_axis = 1'b1; c_idle = 1'($urandom_range(0, 1)); c_blk = ~c_idle; c_clr = 1'b0;
      tick();
      checks++; if (c_kb !== 1'b1 || c_cnt !== 16'd1) begin errors++; $display("FAIL th1_entry %0d got kb=%0d cnt=%0d exp 1 1", i, c_kb, c_cnt); end
      checks++; if (c_dc !== m_dc[2][7:0]) begin errors++; $display("FAIL th1_dc %0d got %0d exp %0d", i, c_dc, m_dc[2]); end
      c_axis = 1'b0; c_clr = 1'b1;
      tick();
      checks++; if (c_kb !== 1'b0 || c_cnt !== 16'd0) begin errors++; $display("FAIL th1_clear %0d got kb=%0d cnt=%0d exp 0 0", i, c_kb, c_cnt); end
    end
    c_clr = 1'b0;
    checks++; if (c_dc !== 8'd255) begin errors++; $display("FAIL th1_dc_sat got %0d exp 255", c_dc); end
  endtask

  task automatic test_async_reset();
    set_a(4'b0100, 2'b10, 2'b01, 1'b0);
    for (int i = 0; i < 9; i++) tick();
    checks++; if (a_kb !== 1'b1 || b_kb !== 1'b1) begin errors++; $display("FAIL areset_pre got a=%0d b=%0d exp 1 1", a_kb, b_kb); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (a_kb !== 1'b0 || a_cnt !== 16'd0 || a_dc !== 8'd0 || a_idx !== 2'd0)
      begin errors++; $display("FAIL areset_a got kb=%0d cnt=%0d dc=%0d idx=%0d exp 0", a_kb, a_cnt, a_dc, a_idx); end
    checks++; if (b_kb !== 1'b0 || b_cnt !== 4'd0 || b_dc !== 8'd0 || b_idx !== 2'd0)
      begin errors++; $display("FAIL areset_b got kb=%0d cnt=%0d dc=%0d idx=%0d exp 0", b_kb, b_cnt, b_dc, b_idx); end
    checks++; if (c_dc !== 8'd0) begin errors++; $display("FAIL areset_c got dc=%0d exp 0", c_dc); end
    model_reset();
    @(posedge clk); #1;
    checks++; if (a_kb !== 1'b0 || a_cnt !== 16'd0) begin errors++; $display("FAIL areset_hold got kb=%0d cnt=%0d exp 0 0", a_kb, a_cnt); end
    rst_n = 1'b1;
    tick();
    checks++; if (a_cnt !== 16'd1 || b_cnt !== 4'd1) begin errors++; $display("FAIL areset_restart got a=%0d b=%0d exp 1 1", a_cnt, b_cnt); end
  endtask

  initial begin
    rst_n = 1'b0;
    set_a(4'd0, 2'd0, 2'd0, 1'b0);
    b_axis = 4'd0; b_idle = 2'd0; b_blk = 2'd0; b_clr = 1'b0;
    c_axis = 1'b0; c_idle = 1'b0; c_blk = 1'b0; c_clr = 1'b0;
    model_reset();
    #2;
    test_reset();
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    test_persistence();
    test_glitch_filter();
    test_progress_masks();
    test_priority_clear();
    test_clear_collision();
    test_random();
    test_threshold_one();
    test_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aesl_deadlock_channel_monitor.md
# aesl_deadlock_channel_monitor

Parametrised kernel-level deadlock monitor for the co-simulation testbench. It watches N AXI-stream channel block flags and M instance idle/block flags, and declares a deadlock only after a stall persists for a programmable number of cycles. It latches the first offending channel index and holds a sticky report until cleared. It replaces the single-channel, unfiltered monitor top in the `gps_translation` simulation harness.

## Interface
- `NUM_AXIS`, 4: number of AXI-stream channels monitored; ≥1.
- `NUM_INST`, 2: number of sub-instances monitored; ≥1.
- `CNT_W`, 16: width of the persistence and stall-cycle counters.
- `THRESHOLD`, 64: consecutive stalled cycles required to declare deadlock; 1 ≤ THRESHOLD ≤ 2^CNT_W−1.
- `IDX_W`, $clog2(NUM_AXIS) (minimum 1): width of the channel index.

Ports:
- `kernel_monitor_clock` in 1: single clock, rising edge.
- `kernel_monitor_reset` in 1: asynchronous, active-low reset.
- `axis_block_sigs` in NUM_AXIS: bit i high means channel i is blocked (inverted `*_blk_n`).
- `inst_idle_sigs` in NUM_INST: instance idle.
- `inst_block_sigs` in NUM_INST: instance blocked.
- `clear` in 1: synchronous release of a latched deadlock.
- `kernel_block` out 1: registered; high while in DEADLOCK.
- `blocked_chan_idx` out IDX_W: lowest blocked channel index captured on DEADLOCK entry.
- `stall_cycles` out CNT_W: current consecutive-stall count, saturating.
- `deadlock_count` out 8: number of DEADLOCK entries since reset, saturating at 255.

## Operation
- Combinational `stall = (|axis_block_sigs) & (&(inst_idle_sigs | inst_block_sigs))`: at least one channel is blocked and no instance is making progress.
- FSM states:
  - IDLE.
  - WATCH.
  - DEADLOCK.
- IDLE:
  - `stall`=1 → WATCH with `stall_cycles`=1.
  - If THRESHOLD=1, go directly to DEADLOCK instead.
- WATCH:
  - `stall`=1 → increment `stall_cycles`. When the incremented value equals THRESHOLD, go to DEADLOCK.
  - `stall`=0 → IDLE with `stall_cycles`=0.
- DEADLOCK (sticky):
  - `stall_cycles` keeps counting while `stall`=1 and saturates at 2^CNT_W−1. It holds when `stall`=0.
  - `clear`=1 → IDLE with `stall_cycles`=0, regardless of `stall`.
- Entry into DEADLOCK:
  - Capture `blocked_chan_idx` from a priority encoder (lowest set bit) over `axis_block_sigs` sampled that same cycle.
  - Increment `deadlock_count`, saturating at 255.
- `blocked_chan_idx` holds its value until the next DEADLOCK entry. It is not cleared by `clear`.
- `clear` in IDLE or WATCH resets `stall_cycles` to 0 and forces IDLE.
- `clear` has priority over any transition into DEADLOCK in the same cycle: no capture, no count increment.

## Timing
- Reset values:
  - state=IDLE.
  - `kernel_block`=0.
  - `blocked_chan_idx`=0.
  - `stall_cycles`=0.
  - `deadlock_count`=0.
- Reset assertion takes effect immediately (asynchronous), including mid-WATCH or in DEADLOCK. Deassertion is sampled at the next rising edge.
- Latency: if `stall` is sampled high at THRESHOLD consecutive rising edges, `kernel_block` is high immediately after the THRESHOLD-th edge.
- A single low sample of `stall` in WATCH restarts the count from 0.
- All outputs are registered. There is no combinational path from inputs to outputs.
- `kernel_block` falls one edge after `clear` is sampled high.

## Structure
- Package `aesl_deadlock_pkg`:
  - `monitor_state_t` enum (IDLE, WATCH, DEADLOCK).
  - Counter saturation constant.
  - `clog2`-based `IDX_W` helper.
- Sub-module `aesl_deadlock_prio_enc`:
  - Parametrised lowest-set-bit encoder, NUM_AXIS → IDX_W.
  - Also outputs a `valid` flag.

## Test plan
- **Persistence trigger.** NUM_AXIS=4, THRESHOLD=8. `axis_block_sigs`=4'b0100, all instances idle for 8 cycles → `kernel_block` rises after edge 8, `blocked_chan_idx`=2, `deadlock_count`=1.
- **Glitch filter.** Stall for 7 cycles, 1 cycle of `stall`=0, then stall again → no DEADLOCK until 8 fresh consecutive cycles; `stall_cycles` returns to 0 on the gap.
- **Progressing instance masks stall.** `axis_block_sigs`=4'b0001 with `inst_idle_sigs`=`inst_block_sigs`=0 for 100 cycles → `kernel_block` stays 0, `stall_cycles` stays 0.
- **Priority and clear.**
  - Deadlock with `axis_block_sigs`=4'b1010 → idx=1.
  - `clear` pulse → `kernel_block`=0 next edge, idx still 1.
  - Re-trigger with 4'b1000 → idx=3, `deadlock_count`=2.
- **Clear vs entry collision.** `clear`=1 on the THRESHOLD-th stall edge → remains out of DEADLOCK, `deadlock_count` unchanged, `stall_cycles`=0.
- **Async reset in DEADLOCK.** Assert `kernel_monitor_reset`=0 between edges → all outputs at reset values immediately; CNT_W=4, THRESHOLD=15 saturation check shows `stall_cycles` stopping at 15.
